keypad_scanner: RTL and testbench

Scanned 4x4 matrix keypad reader for the board's player-input path. It is the input-side counterpart of the 8x8 dot-matrix row/column scan: it drives one keypad column low at a time and reads the row lines back. It then debounces the result and emits a single one-cycle strobe carrying a 4-bit key code per accepted press. The strobe feeds game-control logic in the same way `left_wall_hit` / `right_wall_hit` feed the score display.

---
 rtl/keypad_scanner.sv | 212 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column at a time, builds a
//   16-bit pressed-key snapshot per frame, debounces it frame by frame and
//   reports each accepted press with a one-cycle strobe and a 4-bit code.
//
// Ports
//   clk_50MHz   in   system clock (only clock)
//   reset       in   synchronous active-low reset
//   keypad_row  in   [3:0] row sense lines, active-low, asynchronous
//   keypad_col  out  [3:0] column drive, active-low, one-cold
//   key_code    out  [3:0] {col_idx, row_idx} of last accepted key
//   key_valid   out  one-cycle strobe on acceptance
//   key_held    out  high from acceptance until release is accepted
//
// Debounce FSM
//   state      | meaning
//   -----------+-----------------------------------------------------
//   S_IDLE     | no key accepted, waiting for a single-key frame
//   S_DEBOUNCE | candidate key seen in cnt consecutive frames
//   S_HELD     | key accepted, waiting for an empty frame
//   S_RELEASE  | empty frames seen cnt times while key still held

module keypad_scanner #(
    parameter int SCAN_DIV        = 5000,
    parameter int DEBOUNCE_FRAMES = 20
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic [3:0] keypad_row,
    output logic [3:0] keypad_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int               DIV_W      = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam int               CNT_W      = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_HELD,
        S_RELEASE
    } state_t;

    // ------------------------------------------------------------------
    // Column scan and row capture
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic [1:0]       col_idx_q;
    logic [1:0]       col_next;
    logic [3:0]       col_drv_q;
    logic [3:0]       row_meta_q;
    logic [3:0]       row_sync_q;
    logic [15:0]      snap_q;
    logic [15:0]      snap_d;
    logic             frame_done_q;
    logic             tick;

    assign tick     = (div_q == DIV_LAST);
    assign col_next = col_idx_q + 2'd1;

    always_comb begin
        snap_d = snap_q;
        snap_d[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
    end

    always_ff @(posedge clk_50MHz) begin
        if (!reset) begin
            div_q        <= '0;
            col_idx_q    <= 2'd0;
            col_drv_q    <= 4'b1110;
            row_meta_q   <= 4'b1111;
            row_sync_q   <= 4'b1111;
            snap_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            row_meta_q   <= keypad_row;
            row_sync_q   <= row_meta_q;
            div_q        <= tick ? '0 : div_q + DIV_W'(1);
            // The snapshot is only complete once column 3 has been stored,
            // so classification looks at it one cycle after that tick.
            frame_done_q <= tick && (col_idx_q == 2'd3);
            if (tick) begin
                snap_q    <= snap_d;
                col_idx_q <= col_next;
                col_drv_q <= ~(4'b0001 << col_next);
            end
        end
    end

    assign keypad_col = col_drv_q;

    // ------------------------------------------------------------------
    // Frame classification
    // ------------------------------------------------------------------
    logic [4:0] pop;
    logic [3:0] key_idx;
    logic       cls_none;
    logic       cls_single;

    // Bit index 4*col+row is already the {col,row} key code.
    always_comb begin
        pop     = 5'd0;
        key_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snap_q[i]) begin
                pop     = pop + 5'd1;
                key_idx = 4'(i);
            end
        end
    end

    assign cls_none   = (pop == 5'd0);
    assign cls_single = (pop == 5'd1);

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;

        if (frame_done_q) begin
            case (state_q)
                S_IDLE: begin
                    if (cls_single) begin
                        cand_d  = key_idx;
                        cnt_d   = CNT_W'(1);
                        state_d = S_DEBOUNCE;
                    end
                end
                S_DEBOUNCE: begin
                    if (cls_single && (key_idx == cand_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_ACCEPT) begin
                            code_d  = cand_q;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            state_d = S_HELD;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (cls_none) begin
                        cnt_d   = CNT_W'(1);
                        state_d = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (cls_none) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_ACCEPT) begin
                            held_d  = 1'b0;
                            state_d = S_IDLE;
                        end
                    end else begin
                        // Bounce during release: back to held, no new strobe.
                        cnt_d   = '0;
                        state_d = S_HELD;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cand_q  <= 4'd0;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Drives keypad_scanner with a behavioural keypad matrix model and checks
//   scan timing, debounce, ghosting, release hysteresis and mid-debounce
//   reset. Accepted key codes are expected through a scoreboard queue.

module tb_keypad_scanner;

    localparam int SCAN_DIV = 8;
    localparam int DEB      = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic       clk_50MHz;
    logic       reset;
    logic [3:0] keypad_row;
    logic [3:0] keypad_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed;   // bit 4*col+row

    int n_checks;
    int n_errors;
    int valid_cnt;
    int sb_q[$];

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_FRAMES(DEB)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .keypad_row(keypad_row),
        .keypad_col(keypad_col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk_50MHz = 1'b0;
    always #5 clk_50MHz = ~clk_50MHz;

    // Keypad matrix: row r pulled low while col c is driven low and key (c,r) pressed.
    always_comb begin
        keypad_row = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!keypad_col[c] && pressed[4*c+r]) keypad_row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance n falling edges, then step just past the edge so the monitor
    // (which runs on the falling edge) has already updated its counters.
    task automatic cycles(input int n);
        repeat (n) @(negedge clk_50MHz);
        #1;
    endtask

    // Return just after keypad_col wraps back to column 0 (start of a frame).
    task automatic align_frame();
        logic [3:0] prev;
        bit         found;
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            prev = keypad_col;
            cycles(1);
            if (keypad_col == 4'b1110 && prev != 4'b1110) found = 1;
        end
        if (!found) check("align_timeout", 0, 1);
    endtask

    function automatic logic [15:0] key_bit(input int c, input int r);
        logic [15:0] one;
        one = 16'd1;
        return one << (4 * c + r);
    endfunction

    // Strobe monitor: pops the scoreboard on every key_valid pulse.
    initial begin
        logic valid_prev;
        int   exp_code;
        valid_prev = 1'b0;
        forever begin
            @(negedge clk_50MHz);
            if (key_valid) begin
                check("valid_one_cycle", valid_prev, 0);
                check("held_at_valid", key_held, 1);
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", key_code, 32'hFFFF_FFFF);
                end else begin
                    exp_code = sb_q.pop_front();
                    check("key_code", key_code, exp_code);
                end
                valid_cnt++;
            end
            valid_prev = key_valid;
        end
    end

    initial begin
        logic [3:0] exp_col;
        int         base;
        n_checks  = 0;
        n_errors  = 0;
        valid_cnt = 0;
        pressed   = '0;
        reset     = 1'b0;

        // Reset and scan sequence
        cycles(3);
        check("rst_col", keypad_col, 4'b1110);
        check("rst_code", key_code, 0);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        reset = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            cycles(1);
            exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
            check("scan_col", keypad_col, exp_col);
        end

        // Bounce: two frames of key (0,3) is one short of acceptance
        align_frame();
        pressed = key_bit(0, 3);
        cycles(2 * FRAME);
        pressed = '0;
        cycles(5 * FRAME);
        check("bounce_valid_cnt", valid_cnt, 0);
        check("bounce_held", key_held, 0);

        // Ghost: two keys together never accept
        align_frame();
        pressed = key_bit(1, 0) | key_bit(3, 2);
        cycles(5 * FRAME);
        check("ghost_valid_cnt", valid_cnt, 0);
        check("ghost_code", key_code, 0);
        check("ghost_held", key_held, 0);
        pressed = '0;
        cycles(2 * FRAME);

        // Clean press of key (2,1)
        align_frame();
        sb_q.push_back(4'b1001);
        pressed = key_bit(2, 1);
        cycles(6 * FRAME);
        check("press_valid_cnt", valid_cnt, 1);
        check("press_held", key_held, 1);
        check("press_code_stable", key_code, 4'b1001);

        // Release hysteresis: 2 empty frames, re-press 4, then 3 empty
        align_frame();
        pressed = '0;
        cycles(2 * FRAME);
        check("hyst_held_after_2_none", key_held, 1);
        pressed = key_bit(2, 1);
        cycles(4 * FRAME);
        check("hyst_held_repress", key_held, 1);
        pressed = '0;
        cycles(2 * FRAME + SCAN_DIV);
        check("hyst_held_before_3rd", key_held, 1);
        cycles(FRAME);
        check("hyst_held_after_3rd", key_held, 0);
        check("hyst_valid_cnt", valid_cnt, 1);
        check("hyst_code", key_code, 4'b1001);

        // Reset mid-debounce with key (1,1) kept pressed
        align_frame();
        pressed = key_bit(1, 1);
        cycles(2 * FRAME);
        reset = 1'b0;
        cycles(3);
        check("mid_rst_col", keypad_col, 4'b1110);
        check("mid_rst_code", key_code, 0);
        check("mid_rst_valid", key_valid, 0);
        check("mid_rst_held", key_held, 0);
        base = valid_cnt;
        sb_q.push_back(4'b0101);
        reset = 1'b1;
        cycles(3 * FRAME);
        check("mid_rst_no_early_valid", valid_cnt, base);
        cycles(1);
        check("mid_rst_valid_pulse", key_valid, 1);
        check("mid_rst_valid_cnt", valid_cnt, base + 1);
        pressed = '0;
        cycles(5 * FRAME);
        check("mid_rst_released", key_held, 0);

        check("sb_empty", sb_q.size(), 0);
        check("total_valid", valid_cnt, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
